// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Redirects beat load-use stalls, and stalls beat memory wait states.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              bubble;

    assign imem_addr  = pc;
    assign pc_plus4   = pc + ADDR_W'(4);
    assign redirect   = branch_taken | jump;
    assign raw_target = branch_taken ? branch_target : jump_target;
    assign target     = {raw_target[ADDR_W-1:2], 2'b00};
    assign bubble     = !redirect && IF_ID_Write && !imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (PCWrite && imem_ready) begin
            pc <= pc_plus4;
        end
    end

    // A bubble keeps pc4 so the ID stage still sees the last valid return address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else if (IF_ID_Write) begin
            if (imem_ready) begin
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end else begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!PCWrite && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage: a table of single-cycle vectors plus
// hand-written reset and wrap/saturation sequences on a second, narrow-counter instance.
module tb_if_fetch_stage;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_stall;
        logic [15:0] e_bubble;
    } vec_t;

    localparam logic [31:0] I0 = 32'h2001_0001;
    localparam logic [31:0] I1 = 32'h2002_0002;
    localparam logic [31:0] I2 = 32'h2003_0003;
    localparam logic [31:0] I3 = 32'h2004_0004;
    localparam logic [31:0] I4 = 32'h2005_0005;
    localparam logic [31:0] I5 = 32'h2006_0006;
    localparam int NVEC = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, IF_ID_Write, branch_taken, jump, imem_ready;
    logic [31:0] branch_target, jump_target, imem_rdata;
    logic [31:0] imem_addr, if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        w_rst_n;
    logic        w_pcw, w_ifw, w_rdy;
    logic [31:0] w_rdata;
    logic [31:0] w_addr, w_instr, w_pc4;
    logic        w_valid;
    logic [1:0]  w_stall, w_bubble;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .PCWrite(w_pcw), .IF_ID_Write(w_ifw),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_ready(w_rdy), .if_id_instr(w_instr),
        .if_id_pc4(w_pc4), .if_id_valid(w_valid),
        .stall_cnt(w_stall), .bubble_cnt(w_bubble)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        PCWrite       = v.pcw;
        IF_ID_Write   = v.ifw;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump          = v.jmp;
        jump_target   = v.jt;
        imem_ready    = v.rdy;
        imem_rdata    = v.rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pcw ifw br bt jmp jt rdy rdata | pc instr pc4 valid stall bubble
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I0, 32'h4,   I0,    32'h4,   1'b1, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I1, 32'h8,   I1,    32'h8,   1'b1, 16'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I2, 32'h8,   I1,    32'h8,   1'b1, 16'd1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I2, 32'h8,   I1,    32'h8,   1'b1, 16'd2, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I2, 32'hC,   I2,    32'hC,   1'b1, 16'd2, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I3, 32'h10,  I3,    32'h10,  1'b1, 16'd2, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, I4, 32'h10,  32'h0, 32'h10,  1'b0, 16'd2, 16'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, I4, 32'h10,  32'h0, 32'h10,  1'b0, 16'd2, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, I4, 32'h10,  32'h0, 32'h10,  1'b0, 16'd2, 16'd3};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I4, 32'h14,  I4,    32'h14,  1'b1, 16'd2, 16'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 32'h200, 1'b1, I5, 32'h100, 32'h0, 32'h0,   1'b0, 16'd3, 16'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h202, 1'b0, I5, 32'h200, 32'h0, 32'h0,   1'b0, 16'd3, 16'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I5, 32'h200, I5,    32'h204, 1'b1, 16'd4, 16'd3};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, I5, 32'h204, I5,    32'h204, 1'b1, 16'd4, 16'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, I0, 32'h204, I5,    32'h204, 1'b1, 16'd4, 16'd3};

        rst_n = 1'b0; w_rst_n = 1'b0;
        PCWrite = 1'b1; IF_ID_Write = 1'b1; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; imem_ready = 1'b0; imem_rdata = '0;
        w_pcw = 1'b1; w_ifw = 1'b1; w_rdy = 1'b0; w_rdata = '0;
        #12;
        rst_n = 1'b1;

        checkOutput("reset.pc",     imem_addr,   32'h0);
        checkOutput("reset.valid",  {31'b0, if_id_valid}, 32'h0);
        checkOutput("reset.instr",  if_id_instr, 32'h0);
        checkOutput("reset.stall",  {16'b0, stall_cnt},  32'h0);
        checkOutput("reset.bubble", {16'b0, bubble_cnt}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.pc", i),     imem_addr,   vecs[i].e_pc);
            checkOutput($sformatf("v%0d.instr", i),  if_id_instr, vecs[i].e_instr);
            checkOutput($sformatf("v%0d.pc4", i),    if_id_pc4,   vecs[i].e_pc4);
            checkOutput($sformatf("v%0d.valid", i),  {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            checkOutput($sformatf("v%0d.stall", i),  {16'b0, stall_cnt},   {16'b0, vecs[i].e_stall});
            checkOutput($sformatf("v%0d.bubble", i), {16'b0, bubble_cnt},  {16'b0, vecs[i].e_bubble});
        end

        // Mid-run async reset from pc=0x40, observed before any clock edge.
        applyStimulus('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, I1, 32'h40, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0});
        checkOutput("mid.jump_pc", imem_addr, 32'h40);
        jump = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid.rst_pc",     imem_addr,   32'h0);
        checkOutput("mid.rst_valid",  {31'b0, if_id_valid}, 32'h0);
        checkOutput("mid.rst_instr",  if_id_instr, 32'h0);
        checkOutput("mid.rst_pc4",    if_id_pc4,   32'h0);
        checkOutput("mid.rst_stall",  {16'b0, stall_cnt},  32'h0);
        checkOutput("mid.rst_bubble", {16'b0, bubble_cnt}, 32'h0);
        #2;
        rst_n = 1'b1;

        // Wrap and saturation on the narrow-counter instance.
        w_rst_n = 1'b1;
        #1;
        checkOutput("wrap.reset_pc", w_addr, 32'hFFFF_FFFC);
        w_rdy = 1'b1; w_rdata = I3;
        @(posedge clk); #1;
        checkOutput("wrap.pc",    w_addr,  32'h0);
        checkOutput("wrap.pc4",   w_pc4,   32'h0);
        checkOutput("wrap.instr", w_instr, I3);
        w_pcw = 1'b0; w_ifw = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("wrap.stall%0d", c), {30'b0, w_stall}, (c >= 3) ? 32'd3 : 32'(c));
        end
        checkOutput("wrap.hold_pc", w_addr, 32'h0);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
